// File: rtl/fir_pkg.sv
// Shared types, reset coefficient set and width helpers for the MAC lowpass FIR.
package fir_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      MAC  = 1'b1
   } fir_state_t;

   localparam int GAUSS_ORDER  = 8;
   localparam int GAUSS_COEF_W = 8;

   // 8th-order Gaussian lowpass, b0 in the most significant slice.
   localparam logic [(GAUSS_ORDER+1)*GAUSS_COEF_W-1:0] GAUSS_COEFS = {
      8'd7, 8'd17, 8'd32, 8'd46, 8'd52, 8'd46, 8'd32, 8'd17, 8'd7
   };

   // Smallest accumulator that holds the sum of `taps` full-scale products.
   function automatic int min_acc_w(input int word_in, input int coef_w, input int taps);
      return word_in + coef_w + $clog2(taps);
   endfunction

   // Smallest address that reaches every tap index.
   function automatic int min_addr_w(input int taps);
      return $clog2(taps);
   endfunction

endpackage

// File: rtl/fir_mac_unit.sv
// Registered unsigned multiply-accumulate with synchronous clear and enable.
// acc_sum exposes acc + a*b so the final tap can be folded into the result
// without an extra cycle.
module fir_mac_unit #(
   parameter int A_W   = 8,
   parameter int B_W   = 8,
   parameter int ACC_W = 20
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             clr,
   input  logic             en,
   input  logic [A_W-1:0]   a,
   input  logic [B_W-1:0]   b,
   output logic [ACC_W-1:0] acc_sum
);

   localparam int PROD_W = A_W + B_W;

   logic [PROD_W-1:0] prod;
   logic [ACC_W-1:0]  acc;

   assign prod    = PROD_W'(a) * PROD_W'(b);
   assign acc_sum = acc + ACC_W'(prod);

   // Accumulator: clear wins over enable.
   always_ff @(posedge clock) begin
      if (reset || clr) begin
         acc <= '0;
      end else if (en) begin
         acc <= acc_sum;
      end
   end

endmodule

// File: rtl/fir_mac_lowpass.sv
// Time-multiplexed FIR lowpass: one MAC walks the taps over ORDER+1 cycles
// per accepted sample.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | in_ready high; accepts a sample or a coefficient write
// MAC   | one tap per cycle; last tap publishes data_out / out_valid
module fir_mac_lowpass
   import fir_pkg::*;
#(
   parameter int ORDER   = 8,
   parameter int WORD_IN = 8,
   parameter int COEF_W  = 8,
   parameter int ACC_W   = WORD_IN + COEF_W + 4,
   parameter int ADDR_W  = 4,
   parameter logic [(ORDER+1)*COEF_W-1:0] DEFAULT_COEFS = GAUSS_COEFS
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [WORD_IN-1:0] data_in,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               coef_we,
   input  logic [ADDR_W-1:0]  coef_addr,
   input  logic [COEF_W-1:0]  coef_data,
   output logic [ACC_W-1:0]   data_out,
   output logic               out_valid
);

   localparam int TAPS = ORDER + 1;
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(ORDER);

   if (ORDER < 1) begin : g_order_chk
      $error("ORDER must be at least 1");
   end
   if (ACC_W < min_acc_w(WORD_IN, COEF_W, TAPS)) begin : g_acc_w_chk
      $error("ACC_W too narrow for ORDER/WORD_IN/COEF_W");
   end
   if (ADDR_W < min_addr_w(TAPS)) begin : g_addr_w_chk
      $error("ADDR_W cannot reach every tap");
   end

   fir_state_t state, state_nxt;

   logic [WORD_IN-1:0] x_dly [TAPS];
   logic [COEF_W-1:0]  coef  [TAPS];
   logic [ADDR_W-1:0]  idx;
   logic               accept;
   logic               mac_en;
   logic               last_tap;
   logic               coef_wr;
   logic [COEF_W-1:0]  coef_sel;
   logic [WORD_IN-1:0] x_sel;
   logic [ACC_W-1:0]   acc_sum;

   // State register.
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state and per-state control strobes.
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      accept    = 1'b0;
      mac_en    = 1'b0;
      last_tap  = 1'b0;
      unique case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               accept    = 1'b1;
               state_nxt = MAC;
            end
         end
         MAC: begin
            mac_en = 1'b1;
            if (idx == LAST_IDX) begin
               last_tap  = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Delay line shifts on acceptance; tap index walks during MAC.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int k = 0; k < TAPS; k++) x_dly[k] <= '0;
         idx <= '0;
      end else if (accept) begin
         x_dly[0] <= data_in;
         for (int k = 1; k < TAPS; k++) x_dly[k] <= x_dly[k-1];
         idx <= '0;
      end else if (mac_en) begin
         idx <= idx + ADDR_W'(1);
      end
   end

   // Out-of-range addresses and writes while busy fall through untouched.
   assign coef_wr = coef_we && (state == IDLE) && (coef_addr <= LAST_IDX);

   // Coefficient registers, reloaded with the default set on reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int k = 0; k < TAPS; k++) coef[k] <= DEFAULT_COEFS[(ORDER-k)*COEF_W +: COEF_W];
      end else if (coef_wr) begin
         for (int k = 0; k < TAPS; k++) begin
            if (coef_addr == ADDR_W'(k)) coef[k] <= coef_data;
         end
      end
   end

   // Operand select for the current tap.
   always_comb begin
      coef_sel = '0;
      x_sel    = '0;
      for (int k = 0; k < TAPS; k++) begin
         if (idx == ADDR_W'(k)) begin
            coef_sel = coef[k];
            x_sel    = x_dly[k];
         end
      end
   end

   fir_mac_unit #(
      .A_W   (COEF_W),
      .B_W   (WORD_IN),
      .ACC_W (ACC_W)
   ) u_mac (
      .clock   (clock),
      .reset   (reset),
      .clr     (accept),
      .en      (mac_en),
      .a       (coef_sel),
      .b       (x_sel),
      .acc_sum (acc_sum)
   );

   // Result register: updated only on the last tap, held otherwise.
   always_ff @(posedge clock) begin
      if (reset) begin
         data_out  <= '0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= last_tap;
         if (last_tap) data_out <= acc_sum;
      end
   end

endmodule
